// File: rtl/mux_n_sel_pkg.sv
// Shared types and constants for the N-channel registered mux with blanking.
package mux_n_sel_pkg;

   typedef enum logic {
      ST_HOLD  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_sel_if.sv
// Channel-select bus: parallel sources and control in, selected sample out.
interface mux_n_sel_if #(
   parameter int WIDTH = 8,
   parameter int CH    = 4,
   parameter int SEL_W = $clog2(CH)
);
   logic [CH-1:0][WIDTH-1:0] din;
   logic                     mode;
   logic [SEL_W-1:0]         sel_in;
   logic                     sel_load;
   logic                     sel_busy;
   logic                     sel_err;
   logic [WIDTH-1:0]         dout;
   logic [SEL_W-1:0]         dout_ch;
   logic                     dout_vld;

   modport master (
      output din, mode, sel_in, sel_load,
      input  sel_busy, sel_err, dout, dout_ch, dout_vld
   );

   modport slave (
      input  din, mode, sel_in, sel_load,
      output sel_busy, sel_err, dout, dout_ch, dout_vld
   );
endinterface

// File: rtl/mux_n_dwell_cnt.sv
// DWELL-modulo counter; tc flags the last cycle of a dwell period.
module mux_n_dwell_cnt #(
   parameter int DWELL = 16,
   parameter int CW    = $clog2(DWELL)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CW-1:0] cnt;

   assign tc = (cnt == CW'(DWELL - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= tc ? '0 : cnt + CW'(1);
   end
endmodule

// File: rtl/mux_n_sel.sv
// CH-channel registered mux with manual select and auto-scan; every channel
// switch inserts one dout_vld-low cycle so no sample mixes two channels.
module mux_n_sel
   import mux_n_sel_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CH    = 4,
   parameter int SEL_W = $clog2(CH),
   parameter int DWELL = 16
) (
   input logic        clk,
   input logic        rst,
   mux_n_sel_if.slave bus
);
   state_t           state, state_nxt;
   logic [SEL_W-1:0] ch, ch_nxt;
   logic             cnt_clr, cnt_en, cnt_tc;
   logic             sel_bad, err_nxt;

   // Widen by one bit so the range test stays meaningful when CH is a power of two.
   assign sel_bad = ({1'b0, bus.sel_in} >= (SEL_W+1)'(CH));

   mux_n_dwell_cnt #(.DWELL(DWELL)) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BLANK;
         ch    <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      case (state)
         ST_BLANK: state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (bus.mode == MODE_SCAN) begin
               if (cnt_tc) begin
                  ch_nxt    = (ch == SEL_W'(CH - 1)) ? '0 : ch + SEL_W'(1);
                  state_nxt = ST_BLANK;
               end
            end else if (bus.sel_load && !sel_bad && bus.sel_in != ch) begin
               ch_nxt    = bus.sel_in;
               state_nxt = ST_BLANK;
            end
         end
         default: state_nxt = ST_BLANK;
      endcase
   end

   // Manual mode pins the counter at zero so a later scan starts a fresh dwell.
   always_comb begin
      bus.sel_busy = (state == ST_BLANK);
      cnt_clr      = (state == ST_BLANK) || (bus.mode == MODE_MANUAL);
      cnt_en       = (state == ST_HOLD) && (bus.mode == MODE_SCAN);
      err_nxt      = (bus.mode == MODE_MANUAL) && bus.sel_load
                     && ((state == ST_BLANK) || sel_bad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dout     <= '0;
         bus.dout_ch  <= '0;
         bus.dout_vld <= 1'b0;
         bus.sel_err  <= 1'b0;
      end else begin
         bus.sel_err <= err_nxt;
         if (state == ST_HOLD) begin
            bus.dout     <= bus.din[ch];
            bus.dout_ch  <= ch;
            bus.dout_vld <= 1'b1;
         end else begin
            bus.dout_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux_n_sel.sv
// Directed bench: stimulus queues hand-computed outputs, a monitor pops and compares.
module tb_mux_n_sel;
   import mux_n_sel_pkg::*;

   typedef struct {
      logic       vld;
      logic [7:0] d;
      logic [1:0] c;
      logic       err;
      logic       busy;
   } exp_t;

   logic clk, rst;
   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mon_n   = 0;

   mux_n_sel_if #(.WIDTH(8), .CH(4), .SEL_W(2)) bus ();

   mux_n_sel #(.WIDTH(8), .CH(4), .SEL_W(2), .DWELL(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s #%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic cyc(input logic m, input logic l, input logic [1:0] s,
                      input logic v, input logic [7:0] d, input logic [1:0] c,
                      input logic e, input logic b);
      exp_t x;
      bus.mode     = m;
      bus.sel_load = l;
      bus.sel_in   = s;
      x = '{v, d, c, e, b};
      q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset(input int idx);
      chk("rst_dout", idx, bus.dout, 8'h00);
      chk("rst_ch",   idx, 8'(bus.dout_ch), 8'h00);
      chk("rst_vld",  idx, 8'(bus.dout_vld), 8'h00);
      chk("rst_err",  idx, 8'(bus.sel_err), 8'h00);
      chk("rst_busy", idx, 8'(bus.sel_busy), 8'h01);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("vld",  mon_n, 8'(bus.dout_vld), 8'(mon_e.vld));
            chk("dout", mon_n, bus.dout, mon_e.d);
            chk("ch",   mon_n, 8'(bus.dout_ch), 8'(mon_e.c));
            chk("err",  mon_n, 8'(bus.sel_err), 8'(mon_e.err));
            chk("busy", mon_n, 8'(bus.sel_busy), 8'(mon_e.busy));
            mon_n++;
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.din      = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      bus.mode     = MODE_MANUAL;
      bus.sel_in   = 2'd0;
      bus.sel_load = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk_reset(0);
      rst = 1'b0;

      // Reset release: one blank edge, then channel 0.
      cyc(0, 0, 0,  0, 8'h00, 0, 0, 0);
      cyc(0, 0, 0,  1, 8'hA0, 0, 0, 0);
      // Manual switch to ch2; a load during the blank is rejected.
      cyc(0, 1, 2,  1, 8'hA0, 0, 0, 1);
      cyc(0, 1, 1,  0, 8'hA0, 0, 1, 0);
      cyc(0, 0, 0,  1, 8'hC2, 2, 0, 0);
      // Reload of the current channel is a no-op.
      cyc(0, 1, 2,  1, 8'hC2, 2, 0, 0);
      cyc(0, 0, 0,  1, 8'hC2, 2, 0, 0);
      // Live data change on the held channel.
      bus.din[2] = 8'h5A;
      cyc(0, 0, 0,  1, 8'h5A, 2, 0, 0);
      bus.din[2] = 8'hC2;
      cyc(0, 0, 0,  1, 8'hC2, 2, 0, 0);
      // Back to ch0 before scanning.
      cyc(0, 1, 0,  1, 8'hC2, 2, 0, 1);
      cyc(0, 0, 0,  0, 8'hC2, 2, 0, 0);
      cyc(0, 0, 0,  1, 8'hA0, 0, 0, 0);
      // Scan: 4 valid + 1 blank per channel, sel_load ignored.
      cyc(1, 0, 0,  1, 8'hA0, 0, 0, 0);
      cyc(1, 1, 3,  1, 8'hA0, 0, 0, 0);
      cyc(1, 0, 0,  1, 8'hA0, 0, 0, 0);
      cyc(1, 0, 0,  1, 8'hA0, 0, 0, 1);
      cyc(1, 0, 0,  0, 8'hA0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'hB1, 1, 0, (i == 3));
      cyc(1, 1, 2,  0, 8'hB1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'hC2, 2, 0, (i == 3));
      cyc(1, 0, 0,  0, 8'hC2, 2, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'hD3, 3, 0, (i == 3));
      cyc(1, 0, 0,  0, 8'hD3, 3, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'hA0, 0, 0, (i == 3));
      cyc(1, 0, 0,  0, 8'hA0, 0, 0, 0);
      // Two dwell cycles on ch1, then drop to manual: ch1 holds indefinitely.
      cyc(1, 0, 0,  1, 8'hB1, 1, 0, 0);
      cyc(1, 0, 0,  1, 8'hB1, 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 8'hB1, 1, 0, 0);
      // Manual mode sampled on the would-be wrap edge suppresses the wrap.
      cyc(1, 0, 0,  1, 8'hB1, 1, 0, 0);
      cyc(1, 0, 0,  1, 8'hB1, 1, 0, 0);
      cyc(1, 0, 0,  1, 8'hB1, 1, 0, 0);
      cyc(0, 0, 0,  1, 8'hB1, 1, 0, 0);
      cyc(0, 0, 0,  1, 8'hB1, 1, 0, 0);
      // Reset asserted during a blank cycle clears outputs immediately.
      cyc(0, 1, 3,  1, 8'hB1, 1, 0, 1);
      rst = 1'b1;
      #1;
      chk_reset(1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      cyc(0, 0, 0,  0, 8'h00, 0, 0, 0);
      cyc(0, 0, 0,  1, 8'hA0, 0, 0, 0);

      for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
